// File: rtl/fizzbuzz_classifier.sv
// Multi-channel divisibility classifier: a serial restoring divider per channel
// reports which programmable divisors evenly divide each accepted value.
module fizzbuzz_classifier #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 2,
    parameter int DW    = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*DW-1:0]    div_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [N_CH-1:0]       out_hit,
    output logic                  out_all,
    input  logic                  cnt_clr,
    output logic [N_CH*CNT_W-1:0] hit_cnt
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     data_q;
    logic [N_CH*DW-1:0]   div_q;
    logic [IW-1:0]        idx_q;
    logic [DW:0]          rem_q     [N_CH];
    logic [DW:0]          rem_nxt   [N_CH];
    logic [DW:0]          rem_shift [N_CH];
    logic [N_CH-1:0]      hit_nxt;
    logic [CNT_W-1:0]     cnt_q     [N_CH];
    logic                 accept;
    logic                 out_fire;

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (idx_q == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // One restoring-division step per channel; the remainder stays below a
    // nonzero divisor, so its top bit is free to absorb the shift.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            rem_shift[c] = {rem_q[c][DW-1:0], data_q[idx_q]};
            if (rem_shift[c] >= {1'b0, div_q[c*DW +: DW]}) begin
                rem_nxt[c] = rem_shift[c] - {1'b0, div_q[c*DW +: DW]};
            end else begin
                rem_nxt[c] = rem_shift[c];
            end
            hit_nxt[c] = (rem_nxt[c] == '0) && (div_q[c*DW +: DW] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            out_hit <= '0;
            for (int c = 0; c < N_CH; c++) begin
                rem_q[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q  <= in_data;
                        div_q   <= div_i;
                        idx_q   <= IW'(WIDTH - 1);
                        out_hit <= '0;
                        for (int c = 0; c < N_CH; c++) begin
                            rem_q[c] <= '0;
                        end
                    end
                end
                CALC: begin
                    for (int c = 0; c < N_CH; c++) begin
                        rem_q[c] <= rem_nxt[c];
                    end
                    if (idx_q == '0) begin
                        out_hit <= hit_nxt;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = data_q;
    assign out_all  = &out_hit;

    // Clear wins over a coincident increment so software sees a clean zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (cnt_clr) begin
                    cnt_q[c] <= '0;
                end else if (out_fire && out_hit[c] && !(&cnt_q[c])) begin
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int c = 0; c < N_CH; c++) begin
            hit_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end

endmodule

// File: tb/tb_fizzbuzz_classifier.sv
// Self-checking bench for fizzbuzz_classifier: directed vector table, counter
// corner cases, mid-operation reset and randomized traffic against a modulo model.
module tb_fizzbuzz_classifier;

    localparam int WIDTH = 8;
    localparam int N_CH  = 2;
    localparam int DW    = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  rst_n;
    logic [N_CH*DW-1:0]    div_i;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [N_CH-1:0]       out_hit;
    logic                  out_all;
    logic                  cnt_clr;
    logic [N_CH*CNT_W-1:0] hit_cnt;

    int total;
    int bad;
    int cnt_m [N_CH];

    typedef struct {
        logic [WIDTH-1:0]   val;
        logic [N_CH*DW-1:0] dv;
        logic [N_CH*DW-1:0] post_dv;
        int                 hold;
        logic [N_CH-1:0]    exp_hit;
    } vec_t;

    vec_t vecs [8];

    fizzbuzz_classifier #(.WIDTH(WIDTH), .N_CH(N_CH), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .div_i(div_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_hit(out_hit), .out_all(out_all),
        .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A channel hits exactly when its divisor is nonzero and divides the value.
    function automatic logic [N_CH-1:0] refHit(input int unsigned val, input logic [N_CH*DW-1:0] dv);
        logic [N_CH-1:0] r;
        r = '0;
        for (int c = 0; c < N_CH; c++) begin
            int unsigned d;
            d = dv[c*DW +: DW];
            r[c] = (d != 0) && ((val % d) == 0);
        end
        return r;
    endfunction

    function automatic logic [N_CH*CNT_W-1:0] packCounts();
        logic [N_CH*CNT_W-1:0] p;
        p = '0;
        for (int c = 0; c < N_CH; c++) begin
            p[c*CNT_W +: CNT_W] = CNT_W'(cnt_m[c]);
        end
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drives one value through the full handshake, optionally stalling the
    // output and clearing counters on the handshake cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] val, input logic [N_CH*DW-1:0] dv,
                                 input logic [N_CH*DW-1:0] post_dv, input int hold,
                                 input logic clr, input logic [N_CH-1:0] exp_hit);
        int waited;
        int lat;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_data   = val;
        div_i     = dv;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        div_i    = post_dv;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(WIDTH));
        checkOutput("out_data", 64'(out_data), 64'(val));
        checkOutput("out_hit", 64'(out_hit), 64'(exp_hit));
        checkOutput("out_all", 64'(out_all), 64'(&exp_hit));
        for (int k = 0; k < hold; k++) begin
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall_data", 64'(out_data), 64'(val));
            checkOutput("stall_hit", 64'(out_hit), 64'(exp_hit));
            @(negedge clk);
        end
        out_ready = 1'b1;
        cnt_clr   = clr;
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (clr) begin
                cnt_m[c] = 0;
            end else if (exp_hit[c] && cnt_m[c] < CNT_MAX) begin
                cnt_m[c] = cnt_m[c] + 1;
            end
        end
        checkOutput("handshake_done", 64'(out_valid), 64'd0);
        checkOutput("in_ready_after", 64'(in_ready), 64'd1);
        checkOutput("hit_cnt", 64'(hit_cnt), 64'(packCounts()));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int c = 0; c < N_CH; c++) cnt_m[c] = 0;

        vecs[0] = '{8'd15,  8'h53, 8'h53, 0, 2'b11};
        vecs[1] = '{8'd9,   8'h53, 8'h53, 0, 2'b01};
        vecs[2] = '{8'd10,  8'h53, 8'h53, 0, 2'b10};
        vecs[3] = '{8'd7,   8'h53, 8'h53, 0, 2'b00};
        vecs[4] = '{8'd30,  8'h53, 8'h53, 4, 2'b11};
        vecs[5] = '{8'd0,   8'h01, 8'h01, 0, 2'b01};
        vecs[6] = '{8'd255, 8'h01, 8'h01, 1, 2'b01};
        vecs[7] = '{8'd21,  8'h53, 8'h77, 0, 2'b01};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        div_i     = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_hit", 64'(out_hit), 64'd0);
        checkOutput("reset_out_all", 64'(out_all), 64'd0);
        checkOutput("reset_hit_cnt", 64'(hit_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].val, vecs[i].dv, vecs[i].post_dv, vecs[i].hold, 1'b0, vecs[i].exp_hit);
        end

        // Clear coinciding with a hit must leave the counter at zero.
        applyStimulus(8'd3, 8'h03, 8'h03, 0, 1'b1, 2'b01);

        // Six multiples of three walk channel 0 into saturation.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(WIDTH'(3 * i), 8'h03, 8'h03, 0, 1'b0, refHit(3 * i, 8'h03));
        end
        checkOutput("saturated_cnt0", 64'(hit_cnt[CNT_W-1:0]), 64'(CNT_MAX));

        // Reset in the middle of a calculation abandons it at once.
        in_valid = 1'b1;
        in_data  = 8'd45;
        div_i    = 8'h53;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midcalc_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midcalc_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midcalc_hit_cnt", 64'(hit_cnt), 64'd0);
        for (int c = 0; c < N_CH; c++) cnt_m[c] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0]   v;
            logic [N_CH*DW-1:0] d;
            v = WIDTH'($urandom);
            d = (N_CH*DW)'($urandom);
            applyStimulus(v, d, (N_CH*DW)'($urandom), int'($urandom_range(0, 2)),
                          ($urandom_range(0, 9) == 0), refHit(v, d));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
